// File: rtl/aes_decrypt_stream_if.sv
// Ciphertext-in / plaintext-out stream bundle for aes_decrypt_stream.
// master drives blocks in and accepts results; slave is the decryptor side.
interface aes_decrypt_stream_if;
    logic [127:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] out_data;
    logic         out_valid;
    logic         out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/aes_decrypt_stream.sv
// Iterative AES inverse cipher, one round per clock, one block in flight.
// Latency: NR cycles from input acceptance to out_valid; peak one block per NR+2 cycles.
// Backpressure: in_ready low from acceptance until the output handshake; DONE holds until out_ready.
module aes_decrypt_stream #(
    parameter int NK = 4,
    parameter int NR = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [128*(NR+1)-1:0] allKeys,
    aes_decrypt_stream_if.slave   io,
    output logic                  busy
);
    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    state_t       state, state_nxt;
    logic [127:0] state_reg;
    logic [127:0] out_reg;
    logic [127:0] t;
    logic [3:0]   rnd;
    logic [127:0] rk [0:NR];
    logic         in_ready;
    logic         out_valid;

    if (NR != NK + 6) begin : g_bad_cfg
        $error("aes_decrypt_stream: NR must equal NK+6");
    end

    for (genvar r = 0; r <= NR; r++) begin : g_rk
        assign rk[r] = allKeys[128*(NR-r) +: 128];
    end

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Inverse affine map, then multiplicative inverse as a^254 (maps 0 to 0).
    function automatic logic [7:0] inv_sbox(input logic [7:0] y);
        logic [7:0] a, a2, a3, a12, a15, a240;
        for (int i = 0; i < 8; i++)
            a[i] = y[(i+2)%8] ^ y[(i+5)%8] ^ y[(i+7)%8];
        a    = a ^ 8'h05;
        a2   = gf_mul(a, a);
        a3   = gf_mul(a2, a);
        a12  = gf_mul(gf_mul(a3, a3), gf_mul(a3, a3));
        a15  = gf_mul(a12, a3);
        a240 = a15;
        for (int i = 0; i < 4; i++)
            a240 = gf_mul(a240, a240);
        return gf_mul(gf_mul(a240, a12), a2);
    endfunction

    function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = inv_sbox(s[127-8*(4*((c-r+4)%4)+r) -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gf_mul(a0,8'h0e) ^ gf_mul(a1,8'h0b) ^ gf_mul(a2,8'h0d) ^ gf_mul(a3,8'h09);
            o[119-32*c -: 8] = gf_mul(a0,8'h09) ^ gf_mul(a1,8'h0e) ^ gf_mul(a2,8'h0b) ^ gf_mul(a3,8'h0d);
            o[111-32*c -: 8] = gf_mul(a0,8'h0d) ^ gf_mul(a1,8'h09) ^ gf_mul(a2,8'h0e) ^ gf_mul(a3,8'h0b);
            o[103-32*c -: 8] = gf_mul(a0,8'h0b) ^ gf_mul(a1,8'h0d) ^ gf_mul(a2,8'h09) ^ gf_mul(a3,8'h0e);
        end
        return o;
    endfunction

    assign t = inv_shift_sub(state_reg) ^ rk[rnd];

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (io.in_valid) state_nxt = ROUND;
            end
            ROUND: begin
                busy = 1'b1;
                if (rnd == 4'd0) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (io.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Final round (rnd == 0) skips InvMixColumns and lands directly in out_reg.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= '0;
            rnd       <= '0;
            out_reg   <= '0;
        end else if (state == IDLE && io.in_valid) begin
            state_reg <= io.in_data ^ rk[NR];
            rnd       <= 4'(NR - 1);
        end else if (state == ROUND) begin
            if (rnd != 4'd0) begin
                state_reg <= inv_mix_columns(t);
                rnd       <= rnd - 4'd1;
            end else begin
                out_reg <= t;
            end
        end
    end

    assign io.in_ready  = in_ready;
    assign io.out_valid = out_valid;
    assign io.out_data  = out_reg;
endmodule

// File: tb/tb_aes_decrypt_stream.sv
// Bench for aes_decrypt_stream: FIPS-197 vectors for all key sizes, then flow-control,
// reset and random round-trip checks against a forward-cipher reference model.
module tb_aes_decrypt_stream;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    aes_decrypt_stream_if if128();
    aes_decrypt_stream_if if192();
    aes_decrypt_stream_if if256();
    logic [128*11-1:0] keys128;
    logic [128*13-1:0] keys192;
    logic [128*15-1:0] keys256;
    logic busy128, busy192, busy256;

    aes_decrypt_stream #(.NK(4), .NR(10)) dut128 (.clk(clk), .reset(reset), .allKeys(keys128), .io(if128), .busy(busy128));
    aes_decrypt_stream #(.NK(6), .NR(12)) dut192 (.clk(clk), .reset(reset), .allKeys(keys192), .io(if192), .busy(busy192));
    aes_decrypt_stream #(.NK(8), .NR(14)) dut256 (.clk(clk), .reset(reset), .allKeys(keys256), .io(if256), .busy(busy256));

    int tests = 0;
    int fails = 0;

`define CHECK(TAG, OBS, EXP) \
    begin \
        tests++; \
        assert ((OBS) === (EXP)) else begin \
            fails++; \
            $error("FAIL %s: observed %0h expected %0h", TAG, OBS, EXP); \
        end \
    end

    logic [7:0] sbox [256];

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // Forward S-box: brute-force field inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv, a;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            a = inv;
            sbox[x] = a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]} ^ {a[3:0], a[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    // Round keys packed with round key 0 in the top 128 bits.
    function automatic logic [1919:0] expand(input logic [255:0] key, input int nk);
        logic [31:0]   w [60];
        logic [31:0]   tmp;
        logic [7:0]    rc;
        logic [1919:0] ks;
        int nr;
        nr = nk + 6;
        rc = 8'h01;
        ks = '0;
        for (int i = 0; i < 4*(nr+1); i++) begin
            if (i < nk) begin
                w[i] = key[255-32*i -: 32];
            end else begin
                tmp = w[i-1];
                if (i % nk == 0) begin
                    tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                    rc  = xt(rc);
                end else if (nk > 6 && i % nk == 4) begin
                    tmp = subw(tmp);
                end
                w[i] = w[i-nk] ^ tmp;
            end
        end
        for (int r = 0; r <= nr; r++)
            ks[1919-128*r -: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return ks;
    endfunction

    function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [1919:0] ks, input int nr);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] blk;
        blk = pt ^ ks[1919 -: 128];
        for (int r = 1; r <= nr; r++) begin
            for (int k = 0; k < 16; k++) s[k] = sbox[blk[127-8*k -: 8]];
            for (int c = 0; c < 4; c++)
                for (int j = 0; j < 4; j++) t[4*c+j] = s[4*((c+j)%4)+j];
            if (r != nr) begin
                for (int c = 0; c < 4; c++) begin
                    s[4*c]   = xt(t[4*c]) ^ xt(t[4*c+1]) ^ t[4*c+1] ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ xt(t[4*c+1]) ^ xt(t[4*c+2]) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ xt(t[4*c+2]) ^ xt(t[4*c+3]) ^ t[4*c+3];
                    s[4*c+3] = xt(t[4*c]) ^ t[4*c] ^ t[4*c+1] ^ t[4*c+2] ^ xt(t[4*c+3]);
                end
            end else begin
                s = t;
            end
            for (int k = 0; k < 16; k++) blk[127-8*k -: 8] = s[k];
            blk = blk ^ ks[1919-128*r -: 128];
        end
        return blk;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Push one block through dut128; out_ready held low for 'hold' cycles of DONE.
    task automatic run_block(input logic [127:0] ct, input int hold, output logic [127:0] res, output int lat);
        int k;
        if128.out_ready = (hold == 0);
        if128.in_data   = ct;
        if128.in_valid  = 1'b1;
        k = 0;
        while (!if128.in_ready && k < 40) begin step(); k++; end
        step();
        if128.in_valid = 1'b0;
        lat = 0;
        while (!if128.out_valid && lat < 40) begin step(); lat++; end
        res = if128.out_data;
        repeat (hold) step();
        if128.out_ready = 1'b1;
        step();
    endtask

    localparam logic [127:0] PT_KAT = 128'h00112233445566778899aabbccddeeff;

    logic [1919:0] ks128, ks192, ks256;
    logic [127:0]  pa, pb, pc, held, res;
    logic [127:0]  got [$];
    int lat128, lat192, lat256, v128, b128, b192, b256, k, bad, lat, acc_n, hold;
    int acc_cyc [2];
    logic accept_now;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end, observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        build_sbox();
        reset = 1'b1;
        if128.in_valid = 0; if128.in_data = '0; if128.out_ready = 1;
        if192.in_valid = 0; if192.in_data = '0; if192.out_ready = 1;
        if256.in_valid = 0; if256.in_data = '0; if256.out_ready = 1;
        ks128 = expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
        ks192 = expand({192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 6);
        ks256 = expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);
        keys128 = ks128[1919 -: 1408];
        keys192 = ks192[1919 -: 1664];
        keys256 = ks256[1919 -: 1920];
        step(); step();
        `CHECK("rst_in_ready", if128.in_ready, 1'b1)
        `CHECK("rst_out_valid", if128.out_valid, 1'b0)
        `CHECK("rst_busy", busy128, 1'b0)
        `CHECK("rst_out_data", if128.out_data, 128'h0)

        // in_valid during reset must not be taken
        if128.in_data = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        if128.in_valid = 1'b1;
        step();
        reset = 1'b0;
        if128.in_valid = 1'b0;
        step();
        `CHECK("rst_vs_valid_busy", busy128, 1'b0)

        // Known-answer vectors on all three key sizes in parallel
        if128.in_data = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        if192.in_data = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
        if256.in_data = 128'h8ea2b7ca516745bfeafc49904b496089;
        if128.in_valid = 1; if192.in_valid = 1; if256.in_valid = 1;
        step();
        if128.in_valid = 0; if192.in_valid = 0; if256.in_valid = 0;
        `CHECK("kat_in_ready_low", if128.in_ready, 1'b0)
        lat128 = -1; lat192 = -1; lat256 = -1; v128 = 0; b128 = 0; b192 = 0; b256 = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy128) b128++;
            if (busy192) b192++;
            if (busy256) b256++;
            if (if128.out_valid) begin v128++; if (lat128 < 0) begin lat128 = i; `CHECK("kat128_data", if128.out_data, PT_KAT) end end
            if (if192.out_valid && lat192 < 0) begin lat192 = i; `CHECK("kat192_data", if192.out_data, PT_KAT) end
            if (if256.out_valid && lat256 < 0) begin lat256 = i; `CHECK("kat256_data", if256.out_data, PT_KAT) end
            step();
        end
        `CHECK("kat128_latency", lat128, 10)
        `CHECK("kat192_latency", lat192, 12)
        `CHECK("kat256_latency", lat256, 14)
        `CHECK("kat128_valid_cycles", v128, 1)
        `CHECK("kat128_busy_cycles", b128, 10)
        `CHECK("kat192_busy_cycles", b192, 12)
        `CHECK("kat256_busy_cycles", b256, 14)

        // Backpressure: result must hold while a competing block waits
        pa = rand128();
        if128.out_ready = 1'b0;
        if128.in_data = encrypt(pa, ks128, 10);
        if128.in_valid = 1'b1;
        step();
        if128.in_valid = 1'b0;
        k = 0;
        while (!if128.out_valid && k < 40) begin step(); k++; end
        `CHECK("bp_latency", k, 10)
        held = if128.out_data;
        `CHECK("bp_data", held, pa)
        pb = rand128();
        if128.in_data = encrypt(pb, ks128, 10);
        if128.in_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (if128.out_valid !== 1'b1 || if128.out_data !== held || if128.in_ready !== 1'b0 || busy128 !== 1'b0) bad++;
        end
        `CHECK("bp_stall_stable", bad, 0)
        if128.out_ready = 1'b1;
        step();
        `CHECK("bp_in_ready_after", if128.in_ready, 1'b1)
        `CHECK("bp_out_valid_drop", if128.out_valid, 1'b0)
        step();
        if128.in_valid = 1'b0;
        k = 0;
        while (!if128.out_valid && k < 40) begin step(); k++; end
        `CHECK("bp_second_data", if128.out_data, pb)
        step();

        // Back-to-back with a fresh random key
        ks128 = expand({rand128(), 128'h0}, 4);
        keys128 = ks128[1919 -: 1408];
        pa = rand128();
        pb = rand128();
        got.delete();
        acc_n = 0;
        acc_cyc[0] = 0; acc_cyc[1] = 0;
        if128.in_data = encrypt(pa, ks128, 10);
        if128.in_valid = 1'b1;
        for (int i = 0; i < 60 && got.size() < 2; i++) begin
            accept_now = if128.in_valid && if128.in_ready;
            if (if128.out_valid && if128.out_ready) got.push_back(if128.out_data);
            step();
            if (accept_now) begin
                if (acc_n < 2) acc_cyc[acc_n] = i;
                acc_n++;
                if (acc_n == 1) if128.in_data = encrypt(pb, ks128, 10);
                else if128.in_valid = 1'b0;
            end
        end
        if128.in_valid = 1'b0;
        `CHECK("b2b_accepts", acc_n, 2)
        `CHECK("b2b_accept_gap", acc_cyc[1] - acc_cyc[0], 12)
        `CHECK("b2b_out_count", got.size(), 2)
        `CHECK("b2b_first", (got.size() > 0) ? got[0] : 128'hx, pa)
        `CHECK("b2b_second", (got.size() > 1) ? got[1] : 128'hx, pb)
        step();

        // Reset in the middle of the rounds
        pc = rand128();
        if128.in_data = encrypt(pc, ks128, 10);
        if128.in_valid = 1'b1;
        step();
        if128.in_valid = 1'b0;
        repeat (4) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        `CHECK("midrst_in_ready", if128.in_ready, 1'b1)
        `CHECK("midrst_out_valid", if128.out_valid, 1'b0)
        `CHECK("midrst_busy", busy128, 1'b0)
        `CHECK("midrst_out_data", if128.out_data, 128'h0)
        bad = 0;
        for (int i = 0; i < 20; i++) begin if (if128.out_valid) bad++; step(); end
        `CHECK("midrst_no_pulse", bad, 0)
        run_block(encrypt(pc, ks128, 10), 0, res, lat);
        `CHECK("midrst_next_data", res, pc)
        `CHECK("midrst_next_latency", lat, 10)

        // Random blocks with random output stalls
        for (int n = 0; n < 6; n++) begin
            pa = rand128();
            hold = $urandom_range(0, 3);
            run_block(encrypt(pa, ks128, 10), hold, res, lat);
            `CHECK("rand_data", res, pa)
            `CHECK("rand_latency", lat, 10)
        end

        // Reset while DONE is stalled
        pa = rand128();
        if128.out_ready = 1'b0;
        if128.in_data = encrypt(pa, ks128, 10);
        if128.in_valid = 1'b1;
        step();
        if128.in_valid = 1'b0;
        k = 0;
        while (!if128.out_valid && k < 40) begin step(); k++; end
        `CHECK("donerst_pre_valid", if128.out_valid, 1'b1)
        reset = 1'b1;
        step();
        reset = 1'b0;
        `CHECK("donerst_out_valid", if128.out_valid, 1'b0)
        `CHECK("donerst_out_data", if128.out_data, 128'h0)
        `CHECK("donerst_in_ready", if128.in_ready, 1'b1)
        if128.out_ready = 1'b1;
        step();
        `CHECK("donerst_no_handshake", if128.out_valid, 1'b0)

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
